// File: rtl/intersection_controller_if.sv
// Request inputs and lamp outputs of the intersection sequencer.
// master = the controller, slave = the lamp drivers / detectors side.
interface intersection_controller_if;
  logic       i_ew_req;
  logic       i_ped_req;
  logic       o_ns_green, o_ns_yellow, o_ns_red;
  logic       o_ew_green, o_ew_yellow, o_ew_red;
  logic       o_walk;
  logic [2:0] o_phase;

  modport master (
    input  i_ew_req, i_ped_req,
    output o_ns_green, o_ns_yellow, o_ns_red,
    output o_ew_green, o_ew_yellow, o_ew_red,
    output o_walk, o_phase
  );

  modport slave (
    output i_ew_req, i_ped_req,
    input  o_ns_green, o_ns_yellow, o_ns_red,
    input  o_ew_green, o_ew_yellow, o_ew_red,
    input  o_walk, o_phase
  );
endinterface

// File: rtl/intersection_controller.sv
// Demand-actuated two-road intersection sequencer with pedestrian walk phase.
// One FSM, one shared saturating cycle timer, Moore lamp outputs.
module intersection_controller #(
  parameter int GREEN_MIN = 7,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW    = 5,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 4
) (
  input logic clk,
  input logic i_rst,
  intersection_controller_if.master bus
);
  localparam int TW = $clog2(GREEN_MAX + 1);
  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW);
  localparam logic [TW-1:0] T_AR   = TW'(ALL_RED);
  localparam logic [TW-1:0] T_WALK = TW'(WALK);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_RED_A     = 3'd2,
    S_WALK      = 3'd3,
    S_EW_GREEN  = 3'd4,
    S_EW_YELLOW = 3'd5,
    S_RED_B     = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          ew_pend, ped_pend;
  logic          enter_ew, enter_walk;

  assign enter_ew   = (state_nxt == S_EW_GREEN) && (state != S_EW_GREEN);
  assign enter_walk = (state_nxt == S_WALK)     && (state != S_WALK);

  // Clear on phase entry beats a same-cycle request: that request is served.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= S_RED_B;
      timer    <= TW'(1);
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  timer <= TW'(1);
      else if (timer != '1)    timer <= timer + 1'b1;
      ew_pend  <= enter_ew   ? 1'b0 : (ew_pend  | bus.i_ew_req);
      ped_pend <= enter_walk ? 1'b0 : (ped_pend | bus.i_ped_req);
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.o_ns_green  = 1'b0;
    bus.o_ns_yellow = 1'b0;
    bus.o_ns_red    = 1'b1;
    bus.o_ew_green  = 1'b0;
    bus.o_ew_yellow = 1'b0;
    bus.o_ew_red    = 1'b1;
    bus.o_walk      = 1'b0;
    bus.o_phase     = state;
    case (state)
      S_NS_GREEN: begin
        bus.o_ns_green = 1'b1;
        bus.o_ns_red   = 1'b0;
        if (timer >= T_GMIN && (ew_pend || ped_pend)) state_nxt = S_NS_YELLOW;
      end
      S_NS_YELLOW: begin
        bus.o_ns_yellow = 1'b1;
        bus.o_ns_red    = 1'b0;
        if (timer == T_YEL) state_nxt = S_RED_A;
      end
      S_RED_A: begin
        if (timer == T_AR) state_nxt = ped_pend ? S_WALK : S_EW_GREEN;
      end
      S_WALK: begin
        bus.o_walk = 1'b1;
        if (timer == T_WALK) state_nxt = ew_pend ? S_EW_GREEN : S_RED_B;
      end
      S_EW_GREEN: begin
        bus.o_ew_green = 1'b1;
        bus.o_ew_red   = 1'b0;
        // Gap-out once minimum is served and the detector is clear, else max-out.
        if ((timer >= T_GMIN && !bus.i_ew_req) || timer == T_GMAX)
          state_nxt = S_EW_YELLOW;
      end
      S_EW_YELLOW: begin
        bus.o_ew_yellow = 1'b1;
        bus.o_ew_red    = 1'b0;
        if (timer == T_YEL) state_nxt = S_RED_B;
      end
      S_RED_B: begin
        if (timer == T_AR) state_nxt = S_NS_GREEN;
      end
      default: state_nxt = S_RED_B;
    endcase
  end
endmodule

// File: tb/tb_intersection_controller.sv
// Directed-vector bench: each scenario lists the expected {phase, lamps}
// for every cycle after reset release and compares cycle by cycle.
module tb_intersection_controller;
  logic clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   failures = 0;

  intersection_controller_if ifc ();

  intersection_controller dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [9:0] NSG = {3'd0, 7'b1000010};
  localparam logic [9:0] NSY = {3'd1, 7'b0100010};
  localparam logic [9:0] RA  = {3'd2, 7'b0010010};
  localparam logic [9:0] WK  = {3'd3, 7'b0010011};
  localparam logic [9:0] EWG = {3'd4, 7'b0011000};
  localparam logic [9:0] EWY = {3'd5, 7'b0010100};
  localparam logic [9:0] RB  = {3'd6, 7'b0010010};

  logic [9:0] exp_q[$];
  logic [9:0] obs;

  function automatic logic [9:0] lamps();
    return {ifc.o_phase, ifc.o_ns_green, ifc.o_ns_yellow, ifc.o_ns_red,
            ifc.o_ew_green, ifc.o_ew_yellow, ifc.o_ew_red, ifc.o_walk};
  endfunction

  task automatic add_exp(input logic [9:0] p, input int n);
    repeat (n) exp_q.push_back(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the single RED_B cycle that follows reset release.
  task automatic do_reset();
    ifc.i_ew_req  = 1'b0;
    ifc.i_ped_req = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 100);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_rest cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_ew_gap();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(EWG, 7); add_exp(EWY, 5); add_exp(RB, 1); add_exp(NSG, 10);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL ew_gap cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ew_req = (i == 3);
    end
  endtask

  task automatic test_ew_maxout();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(EWG, 15); add_exp(EWY, 5); add_exp(RB, 1);
    add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1); add_exp(EWG, 3);
    do_reset();
    ifc.i_ew_req = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL ew_maxout cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
    end
    ifc.i_ew_req = 1'b0;
  endtask

  task automatic test_ped();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(WK, 4); add_exp(RB, 1); add_exp(NSG, 15);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL ped_only cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ped_req = (i == 2);
    end
  endtask

  // Request landing on the WALK entry edge is served by that walk.
  task automatic test_clear_wins();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(WK, 4); add_exp(RB, 1); add_exp(NSG, 15);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL clear_wins cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ped_req = (i == 2) || (i == 13);
    end
  endtask

  task automatic test_ped_during_walk();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(WK, 4); add_exp(RB, 1);
    add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(WK, 4); add_exp(RB, 1); add_exp(NSG, 10);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL ped_in_walk cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ped_req = (i == 2) || (i == 15);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(WK, 4); add_exp(EWG, 7); add_exp(EWY, 5); add_exp(RB, 1);
    add_exp(NSG, 10);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL ped_and_ew cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ped_req = (i == 2);
      ifc.i_ew_req  = (i == 2);
    end
  endtask

  // Reset in EW green cycle 5 with a walk pending must discard the request.
  task automatic test_mid_reset();
    exp_q.delete();
    add_exp(RB, 1); add_exp(NSG, 7); add_exp(NSY, 5); add_exp(RA, 1);
    add_exp(EWG, 5); add_exp(RB, 1); add_exp(NSG, 20);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      obs = lamps();
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
      end
      ifc.i_ew_req  = (i == 2);
      ifc.i_ped_req = (i == 14);
      i_rst         = (i == 18);
    end
  endtask

  initial begin
    i_rst         = 1'b1;
    ifc.i_ew_req  = 1'b0;
    ifc.i_ped_req = 1'b0;
    test_reset();
    test_ew_gap();
    test_ew_maxout();
    test_ped();
    test_clear_wins();
    test_ped_during_walk();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
